// File: rtl/cacheline_burst_adapter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cacheline_adapter_pkg: shared types and beat-index helper for the    |
// | line<->burst adapter.                                                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cacheline_adapter_pkg;

  localparam int MAX_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } burst_state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } burst_op_t;

  // Beat index wraps modulo 2**idx_w, so CWF bursts roll over to beat 0.
  function automatic logic [MAX_IDX_W-1:0] beat_index(
    input logic [MAX_IDX_W-1:0] s,
    input logic [MAX_IDX_W-1:0] k,
    input int                   idx_w
  );
    logic [MAX_IDX_W-1:0] mask;
    mask = MAX_IDX_W'((1 << idx_w) - 1);
    return (s + k) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_burst_adapter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cacheline_burst_adapter_if: LLC-side and memory-side bus signals of  |
// | the line<->burst adapter.                                             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface cacheline_burst_adapter_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic               crit_valid_o;
  logic [BURST_W-1:0] crit_word_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, crit_valid_o, crit_word_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, crit_valid_o, crit_word_o, burst_o, address_o, read_o, write_o
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_burst_adapter_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_beat_counter: beat count k and start index s; yields the       |
// | current wrapped beat index.                                           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module burst_beat_counter
  import cacheline_adapter_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] start_o,
  output logic [IDX_W-1:0] index_o,
  output logic             first_o,
  output logic             last_o
);
  logic [IDX_W-1:0] r_s;
  logic [IDX_W-1:0] r_k;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s <= '0;
      r_k <= '0;
    end else if (load_i) begin
      r_s <= start_i;
      r_k <= '0;
    end else if (advance_i) begin
      r_k <= r_k + IDX_W'(1);
    end
  end

  assign start_o = r_s;
  assign index_o = IDX_W'(beat_index(MAX_IDX_W'(r_s), MAX_IDX_W'(r_k), IDX_W));
  assign first_o = (r_k == '0);
  assign last_o  = (r_k == IDX_W'(BEATS - 1));
endmodule
`default_nettype wire

// File: rtl/cacheline_burst_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cacheline_burst_adapter: splits/reassembles an LLC line into memory  |
// | beats, with optional critical-word-first reads.                      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cacheline_burst_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32,
  parameter int CWF     = 1
) (
  input logic                      clk,
  input logic                      reset,
  cacheline_burst_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BURST_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << (OFF_W + IDX_W)) - 64'd1);

  generate
    if (LINE_W % BURST_W != 0) begin : g_chk_line_mult
      $error("LINE_W must be a multiple of BURST_W");
    end
    if (BURST_W % 8 != 0) begin : g_chk_burst_bytes
      $error("BURST_W must be a multiple of 8");
    end
    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_chk_beats
      $error("BEATS must be a power of two and at least 2");
    end
    if (IDX_W > MAX_IDX_W) begin : g_chk_idx_w
      $error("IDX_W exceeds MAX_IDX_W");
    end
    if (ADDR_W <= OFF_W + IDX_W) begin : g_chk_addr_w
      $error("ADDR_W too small for line offset");
    end
    if (CWF != 0 && CWF != 1) begin : g_chk_cwf
      $error("CWF must be 0 or 1");
    end
  endgenerate

  burst_state_t      r_state;
  burst_state_t      w_next;
  burst_op_t         w_op;
  logic [LINE_W-1:0] r_line;
  logic [ADDR_W-1:0] r_addr;
  logic              r_crit;
  logic              w_load;
  logic              w_advance;
  logic              w_rd;
  logic              w_wr;
  logic              w_resp;
  logic [IDX_W-1:0]  w_start;
  logic [IDX_W-1:0]  w_s;
  logic [IDX_W-1:0]  w_b;
  logic              w_first;
  logic              w_last;

  burst_beat_counter #(
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (w_load),
    .start_i   (w_start),
    .advance_i (w_advance),
    .start_o   (w_s),
    .index_o   (w_b),
    .first_o   (w_first),
    .last_o    (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_op      = OP_NONE;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_resp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.read_i) begin
          w_op = OP_READ;
        end else if (bus.write_i) begin
          w_op = OP_WRITE;
        end
        if (w_op == OP_READ) begin
          w_next = RD;
          w_load = 1'b1;
        end else if (w_op == OP_WRITE) begin
          w_next = WR;
          w_load = 1'b1;
        end
      end
      RD, WR: begin
        w_rd = (r_state == RD);
        w_wr = (r_state == WR);
        if (bus.resp_i) begin
          w_advance = 1'b1;
          if (w_last) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        w_resp = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Writes always stream linearly; only reads honour critical-word-first.
  assign w_start = (w_op == OP_READ && CWF != 0) ? bus.address_i[OFF_W +: IDX_W] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line <= '0;
      r_addr <= '0;
      r_crit <= 1'b0;
    end else begin
      r_crit <= (r_state == RD) && bus.resp_i && w_first;
      if (w_load) begin
        r_addr <= bus.address_i;
        if (w_op == OP_WRITE) begin
          r_line <= bus.line_i;
        end
      end else if (r_state == RD && bus.resp_i) begin
        r_line[BURST_W*w_b +: BURST_W] <= bus.burst_i;
      end
    end
  end

  assign bus.line_o       = r_line;
  assign bus.burst_o      = r_line[BURST_W*w_b +: BURST_W];
  assign bus.crit_word_o  = r_line[BURST_W*w_s +: BURST_W];
  assign bus.crit_valid_o = r_crit;
  assign bus.address_o    = (r_addr & ~LINE_MASK) | (ADDR_W'(w_s) << OFF_W);
  assign bus.read_o       = w_rd;
  assign bus.write_o      = w_wr;
  assign bus.resp_o       = w_resp;
endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cacheline_burst_adapter: scoreboard bench for the line<->burst    |
// | adapter (CWF=1 256/64 instance plus a CWF=0 512/128 instance).       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cacheline_burst_adapter;

  typedef struct {
    bit          is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [63:0]  crit;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   beats_seen;
  int   crit_seen;
  bit   stall_rand;
  exp_t        exp_q[$];
  logic [63:0] mem_q[$];
  bit          pat_q[$];

  cacheline_burst_adapter_if #(.LINE_W(256), .BURST_W(64),  .ADDR_W(32)) bus ();
  cacheline_burst_adapter_if #(.LINE_W(512), .BURST_W(128), .ADDR_W(32)) b2 ();

  cacheline_burst_adapter #(.LINE_W(256), .BURST_W(64), .ADDR_W(32), .CWF(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cacheline_burst_adapter #(.LINE_W(512), .BURST_W(128), .ADDR_W(32), .CWF(0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: drives resp_i (pattern, random or always-on) and supplies read beats.
  initial begin
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    forever begin
      @(negedge clk);
      if (bus.read_o || bus.write_o) begin
        if (pat_q.size() > 0) bus.resp_i = pat_q.pop_front();
        else if (stall_rand)  bus.resp_i = ($urandom_range(0, 3) != 0);
        else                  bus.resp_i = 1'b1;
      end else begin
        bus.resp_i = 1'b0;
      end
      if (bus.read_o && bus.resp_i && mem_q.size() > 0) bus.burst_i = mem_q.pop_front();
      else bus.burst_i = {$urandom, $urandom};
    end
  end

  // Monitor: compares each accepted beat, critical word and completion against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if ((bus.read_o || bus.write_o) && bus.resp_i) begin
          if (exp_q.size() == 0) begin
            chk("beat_without_txn", 1, 0);
          end else begin
            chk("beat_dir_rd", bus.read_o, !exp_q[0].is_wr);
            chk("beat_dir_wr", bus.write_o, exp_q[0].is_wr);
            if (beats_seen == 0) chk("address_o", bus.address_o, exp_q[0].addr);
            if (bus.write_o && beats_seen < 4)
              chk("burst_o", bus.burst_o, exp_q[0].line[64*beats_seen +: 64]);
          end
          beats_seen++;
        end
        if (bus.crit_valid_o) begin
          crit_seen++;
          if (exp_q.size() == 0 || exp_q[0].is_wr) chk("crit_unexpected", 1, 0);
          else chk("crit_word_o", bus.crit_word_o, exp_q[0].crit);
        end
        if (bus.resp_o) begin
          if (exp_q.size() == 0) begin
            chk("resp_without_txn", 1, 0);
          end else begin
            e = exp_q.pop_front();
            if (!e.is_wr) chk("line_o", bus.line_o, e.line);
            chk("beat_count", beats_seen, 4);
            chk("crit_count", crit_seen, e.is_wr ? 0 : 1);
            chk("resp_bus_idle", {bus.read_o, bus.write_o}, 2'b00);
          end
          beats_seen = 0;
          crit_seen  = 0;
        end
      end
    end
  end

  task automatic queue_read(input logic [31:0] addr);
    exp_t        e;
    logic [63:0] bt;
    int          s;
    s      = int'((addr >> 3) % 4);
    e.is_wr = 1'b0;
    e.line  = '0;
    e.addr  = (addr & ~32'h1f) + 32'(s * 8);
    e.crit  = '0;
    for (int j = 0; j < 4; j++) begin
      bt = {$urandom, $urandom};
      if (j == 0) e.crit = bt;
      e.line[64*((s + j) % 4) +: 64] = bt;
      mem_q.push_back(bt);
    end
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input bit chk_lat);
    exp_t e;
    int   cyc;
    if (rd) begin
      queue_read(addr);
    end else begin
      e.is_wr = 1'b1;
      e.addr  = addr & ~32'h1f;
      e.line  = wline;
      e.crit  = '0;
      exp_q.push_back(e);
    end
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = wline;
    @(negedge clk);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = $urandom;
    bus.line_i    = {8{$urandom}};
    cyc = 1;
    while (!bus.resp_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.resp_o) chk("resp_timeout", 0, 1);
    else if (chk_lat) chk("latency", cyc, 5);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] rl;
    reset         = 1'b1;
    total         = 0;
    bad           = 0;
    beats_seen    = 0;
    crit_seen     = 0;
    stall_rand    = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    b2.line_i     = '0;
    b2.address_i  = '0;
    b2.read_i     = 1'b0;
    b2.write_i    = 1'b0;
    b2.burst_i    = '0;
    b2.resp_i     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read_o", bus.read_o, 0);
    chk("rst_write_o", bus.write_o, 0);
    chk("rst_resp_o", bus.resp_o, 0);
    chk("rst_crit_valid", bus.crit_valid_o, 0);
    chk("rst_line_o", bus.line_o, 0);
    chk("rst_address_o", bus.address_o, 0);
    chk("rst_burst_o", bus.burst_o, 0);
    chk("rst_crit_word", bus.crit_word_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // CWF read from the top beat, no stalls
    run_txn(1'b1, 1'b0, 32'h0000_1018, '0, 1'b1);
    // linear write, no stalls
    run_txn(1'b0, 1'b1, 32'h0000_0040,
            {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
             64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000}, 1'b1);
    // read with a fixed stall pattern
    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    run_txn(1'b1, 1'b0, 32'h0000_2008, '0, 1'b0);
    // simultaneous read and write: read wins
    run_txn(1'b1, 1'b1, 32'h0000_3010, {8{32'hBADC_0DE5}}, 1'b0);

    // reset after two read beats aborts the transaction
    pat_q = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    queue_read(32'h0000_4000);
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_4000;
    @(negedge clk);
    bus.read_i = 1'b0;
    for (int i = 0; i < 20 && beats_seen < 2; i++) begin
      @(negedge clk);
      #2;
    end
    chk("pre_reset_beats", beats_seen, 2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("abort_read_o", bus.read_o, 0);
    chk("abort_resp_o", bus.resp_o, 0);
    chk("abort_line_o", bus.line_o, 0);
    chk("abort_address_o", bus.address_o, 0);
    reset = 1'b0;
    exp_q.delete();
    mem_q.delete();
    pat_q.delete();
    beats_seen = 0;
    crit_seen  = 0;
    repeat (8) @(negedge clk);
    run_txn(1'b1, 1'b0, 32'h0000_5008, '0, 1'b1);

    // randomized traffic with random stalls
    stall_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(0, 2);
      rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(op != 1, op != 0, $urandom, rl, 1'b0);
    end
    stall_rand = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // CWF=0, 512/128 instance: linear read from a mid-line address
    begin : cwf0_test
      logic [127:0] bt[4];
      logic [511:0] exp2;
      int           n;
      int           j;
      int           ncrit;
      bit           done2;
      for (int i = 0; i < 4; i++) bt[i] = {$urandom, $urandom, $urandom, $urandom};
      exp2 = {bt[3], bt[2], bt[1], bt[0]};
      b2.address_i = 32'h30;
      b2.read_i    = 1'b1;
      b2.resp_i    = 1'b1;
      @(negedge clk);
      b2.read_i    = 1'b0;
      b2.address_i = 32'hFFFF_FFFF;
      n = 1; j = 0; ncrit = 0; done2 = 1'b0;
      while (!done2 && n < 50) begin
        if (b2.read_o) begin
          if (j == 0) chk("cwf0_address_o", b2.address_o, 32'h0);
          if (j < 4) b2.burst_i = bt[j];
          j++;
        end
        if (b2.write_o) chk("cwf0_write_o", b2.write_o, 0);
        if (b2.crit_valid_o) begin
          ncrit++;
          chk("cwf0_crit_word", b2.crit_word_o, bt[0]);
        end
        if (b2.resp_o) begin
          chk("cwf0_line_o", b2.line_o, exp2);
          chk("cwf0_latency", n, 5);
          chk("cwf0_crit_count", ncrit, 1);
          done2 = 1'b1;
        end else begin
          @(negedge clk);
          n++;
        end
      end
      if (!done2) chk("cwf0_timeout", 0, 1);
      b2.resp_i = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
